gpc_4t_fetch: RTL and testbench
===============================

Name: gpc_4t_fetch

Overview:
- Instruction fetch stage for the 4-thread barrel core; sits directly upstream of the instruction memory.
- Holds one PC per hardware thread and selects one enabled thread per cycle, round-robin.
- Drives the memory's address/rden lines and pairs the registered instruction word returned one cycle later with its PC and thread id.
- Accepts per-thread redirects (branch/jump) and a global stall from the decode stage.

Parameters:
- NUM_THREADS, 4, hardware thread count; must be a power of 2.
- RESET_PC, 32'h0000_0000, PC loaded into thread 0 at reset.
- THREAD_PC_STRIDE, 32'h0000_0200, reset PC of thread t is RESET_PC + t*THREAD_PC_STRIDE.
- I_MEM_SIZE, 'h800, instruction memory size in bytes; PC offsets wrap modulo this size.

Ports:
- clock, input, 1, core clock.
- rst, input, 1, asynchronous active-high reset.
- thread_en, input, NUM_THREADS, per-thread fetch enable mask.
- stall, input, 1, decode cannot accept; freeze fetch.
- jmp_valid, input, 1, redirect request.
- jmp_tid, input, 2, thread being redirected.
- jmp_target, input, 32, new PC (bits [1:0] ignored).
- imem_address, output, 32, byte address to instruction memory.
- imem_rden, output, 1, read enable to instruction memory.
- imem_wren, output, 1, tied 0.
- imem_data, output, 32, tied 0.
- imem_q, input, 32, instruction word; registered inside the memory, valid one cycle after address.
- instr_valid, output, 1, instruction output is valid.
- instr, output, 32, instruction word (imem_q pass-through).
- instr_pc, output, 32, PC of instr.
- instr_tid, output, 2, thread of instr.

Behaviour:
- Reset (async, rst=1):
  - pc[t] = RESET_PC + t*THREAD_PC_STRIDE.
  - Round-robin pointer rr_ptr = NUM_THREADS-1, so thread 0 is selected first.
  - Issue stage empty.
  - Outputs: imem_rden=0, imem_address=RESET_PC, instr_valid=0, instr_pc=0, instr_tid=0.
- Select (combinational): sel_tid is the first enabled thread after rr_ptr, cyclic order. If thread_en==0, nothing issues: imem_rden=0, and instr_valid goes 0 next cycle.
- Issue cycle N (stall=0, a thread selected):
  - imem_address = {pc[sel_tid][31:2],2'b00} taken modulo I_MEM_SIZE; imem_rden=1.
  - Registers: issued_pc, issued_tid, issued_vld=1, rr_ptr=sel_tid.
  - pc[sel_tid] += 4, wrapping from I_MEM_SIZE-4 back to 0.
- Response cycle N+1: instr_valid=issued_vld, instr=imem_q, instr_pc=issued_pc, instr_tid=issued_tid. Fixed latency is 1 cycle from address to instr_valid.
- Stall:
  - imem_address and all state (pc, rr_ptr, issued_*) hold.
  - The memory re-reads the same address, so instr/instr_pc/instr_tid stay stable.
  - instr_valid holds its value; the consumer samples only when stall=0.
- Redirect (jmp_valid=1):
  - pc[jmp_tid] = jmp_target & ~3 at the next edge. This overrides the +4 increment and is applied even during a stall.
  - If jmp_tid == sel_tid in the same cycle, this cycle's issue is killed (issued_vld=0) and rr_ptr still advances.
  - If issued_tid == jmp_tid and issued_vld=1 (a younger wrong-path fetch is in flight), issued_vld is cleared and instr_valid=0 for that instruction.
- Disabled thread: a thread disabled while its fetch is in flight still completes. Its PC is frozen until it is re-enabled.
- One instruction per thread in flight at most, by construction of the barrel; no internal buffering.

Optional Feature:
- Macro GPC_4T_FETCH_PERF_EN.
- When defined:
  - Adds a 32-bit fetch_cnt[t] per thread, incremented on each delivered instr_valid with stall=0.
  - Adds a 16-bit kill_cnt, incremented per killed fetch.
  - Exposes both on output ports perf_fetch_cnt (NUM_THREADS*32) and perf_kill_cnt (16).
  - Counters saturate at all-ones and reset to 0.
- When undefined: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- gpc_4t_pkg gains:
  - NUM_THREADS, I_MEM_SIZE, RESET_PC and THREAD_PC_STRIDE constants.
  - typedef t_tid (logic[1:0]).
  - typedef struct t_fetch_req {vld, pc, tid}.
- All flops use the codebase MSFF macros with async reset variants.
- One sub-module: gpc_4t_rr_arb (NUM_THREADS-wide round-robin arbiter: mask, last pointer -> grant one-hot/index, any).

Test Plan:
- Reset, thread_en=4'b1111, no jumps -> issue order tid 0,1,2,3,0...; first instr_valid one cycle after rden. Thread 0 fetches 0x000 then 0x004; thread 1 fetches 0x200 then 0x204; instr matches preloaded memory.
- thread_en=4'b0101 -> tids alternate 0,2,0,2. thread_en=0 -> imem_rden=0 and instr_valid=0 from the next cycle.
- stall high 3 cycles mid-stream -> imem_address, instr, instr_pc, instr_tid constant. After release, the sequence resumes with no skipped or duplicated PC.
- jmp_valid, jmp_tid=1, jmp_target=0x103 while tid 1 is in flight -> that instruction is delivered with instr_valid=0. The next tid-1 fetch is at 0x100, then 0x104.
- Thread 3 PC at 0x7FC -> next thread-3 fetch at 0x000. Assert rst mid-stream -> outputs clear immediately (asynchronous reset) and PCs return to 0x000/0x200/0x400/0x600.
- With GPC_4T_FETCH_PERF_EN: 8 fetches on tid 0 and 1 kill -> perf_fetch_cnt[0]=8, perf_kill_cnt=1.

Source files
------------

// File: rtl/gpc_4t_fetch_pkg.sv
// Shared constants and types for the 4-thread barrel fetch stage.
package gpc_4t_fetch_pkg;

    localparam int          NUM_THREADS      = 4;
    localparam int          TID_W            = $clog2(NUM_THREADS);
    localparam logic [31:0] RESET_PC         = 32'h0000_0000;
    localparam logic [31:0] THREAD_PC_STRIDE = 32'h0000_0200;
    localparam logic [31:0] I_MEM_SIZE       = 32'h0000_0800;

    // I_MEM_SIZE is a power of two, so "modulo size" is a mask.
    localparam logic [31:0] PC_MASK   = I_MEM_SIZE - 32'd1;
    localparam logic [31:0] ADDR_MASK = PC_MASK & ~32'd3;

    typedef logic [TID_W-1:0] t_tid;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        t_tid        tid;
    } t_fetch_req;

    // Reset PC of thread t.
    function automatic logic [31:0] f_reset_pc(input int t);
        return RESET_PC + 32'(t) * THREAD_PC_STRIDE;
    endfunction

endpackage

// File: rtl/gpc_4t_fetch_if.sv
// Fetch-stage bus: decode-side control, instruction memory port and the
// instruction output. master = fetch stage, slave = its environment.
interface gpc_4t_fetch_if;
    import gpc_4t_fetch_pkg::*;

    logic [NUM_THREADS-1:0] thread_en;
    logic                   stall;
    logic                   jmp_valid;
    t_tid                   jmp_tid;
    logic [31:0]            jmp_target;
    logic [31:0]            imem_address;
    logic                   imem_rden;
    logic                   imem_wren;
    logic [31:0]            imem_data;
    logic [31:0]            imem_q;
    logic                   instr_valid;
    logic [31:0]            instr;
    logic [31:0]            instr_pc;
    t_tid                   instr_tid;

    modport master (
        input  thread_en, stall, jmp_valid, jmp_tid, jmp_target, imem_q,
        output imem_address, imem_rden, imem_wren, imem_data,
        output instr_valid, instr, instr_pc, instr_tid
    );

    modport slave (
        output thread_en, stall, jmp_valid, jmp_tid, jmp_target, imem_q,
        input  imem_address, imem_rden, imem_wren, imem_data,
        input  instr_valid, instr, instr_pc, instr_tid
    );

endinterface

// File: rtl/gpc_4t_fetch_rr_arb.sv
// Round-robin arbiter: picks the first set bit of i_mask strictly after
// i_last in cyclic order. NUM_REQ must be a power of two so the index
// arithmetic wraps naturally. With an empty mask o_idx is 0 and o_any is 0.
module gpc_4t_rr_arb
    import gpc_4t_fetch_pkg::*;
#(
    parameter int NUM_REQ = NUM_THREADS,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Scan from the farthest candidate down to the nearest so the nearest
    // enabled requester after i_last wins; i_last itself is lowest priority.
    always_comb begin
        o_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (i_mask[i_last + IDX_W'(k)])
                o_idx = i_last + IDX_W'(k);
        end
    end

    assign o_any = |i_mask;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_gnt
        assign o_gnt[g] = o_any && (o_idx == IDX_W'(g));
    end

endmodule

// File: rtl/gpc_4t_fetch.sv
// Instruction fetch for the 4-thread barrel core. One PC per thread, one
// enabled thread issued per cycle round-robin, fixed 1-cycle memory latency.
// Optional feature macro: GPC_4T_FETCH_PERF_EN adds per-thread delivered-fetch
// counters and a killed-fetch counter on perf_fetch_cnt / perf_kill_cnt.
module gpc_4t_fetch
    import gpc_4t_fetch_pkg::*;
(
    input  logic           clock,
    input  logic           rst,
    gpc_4t_fetch_if.master bus
`ifdef GPC_4T_FETCH_PERF_EN
    ,
    output logic [NUM_THREADS*32-1:0] perf_fetch_cnt,
    output logic [15:0]               perf_kill_cnt
`endif
);

    logic [31:0]            r_pc [NUM_THREADS];
    t_tid                   r_rr_ptr;
    t_fetch_req             r_iss;
    logic [31:0]            r_addr;
    logic                   r_rden;

    logic [NUM_THREADS-1:0] w_gnt;
    t_tid                   w_sel;
    logic                   w_any;
    logic                   w_issue;
    logic                   w_issue_kill;
    logic                   w_resp_kill;
    logic [31:0]            w_addr_new;

    gpc_4t_rr_arb #(
        .NUM_REQ (NUM_THREADS)
    ) u_arb (
        .i_mask (bus.thread_en),
        .i_last (r_rr_ptr),
        .o_gnt  (w_gnt),
        .o_idx  (w_sel),
        .o_any  (w_any)
    );

    assign w_addr_new   = r_pc[w_sel] & ADDR_MASK;
    assign w_issue      = !bus.stall && w_any;
    // Redirect hitting the thread being selected this cycle.
    assign w_issue_kill = w_issue && bus.jmp_valid && (bus.jmp_tid == w_sel);
    // Redirect hitting the thread whose fetch is in flight: wrong path.
    assign w_resp_kill  = r_iss.vld && bus.jmp_valid && (bus.jmp_tid == r_iss.tid);

    // Per-thread PC: redirect wins over the post-issue increment, and a
    // redirect is taken even while stalled.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++)
                r_pc[t] <= f_reset_pc(t);
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (bus.jmp_valid && bus.jmp_tid == t_tid'(t))
                    r_pc[t] <= bus.jmp_target & ~32'd3;
                else if (w_issue && w_gnt[t])
                    r_pc[t] <= (r_pc[t] + 32'd4) & PC_MASK;
            end
        end
    end

    // Issue register and round-robin pointer; held during stall except for
    // dropping a wrong-path fetch.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= t_tid'(NUM_THREADS - 1);
            r_iss    <= '0;
        end else if (!bus.stall) begin
            r_iss.vld <= w_issue && !w_issue_kill;
            if (w_issue) begin
                r_rr_ptr  <= w_sel;
                r_iss.pc  <= w_addr_new;
                r_iss.tid <= w_sel;
            end
        end else if (w_resp_kill) begin
            r_iss.vld <= 1'b0;
        end
    end

    // Last memory request, replayed while stalled so the registered memory
    // output (and therefore instr) stays stable.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_addr <= RESET_PC & ADDR_MASK;
            r_rden <= 1'b0;
        end else if (!bus.stall) begin
            r_addr <= w_addr_new;
            r_rden <= w_any;
        end
    end

    assign bus.imem_address = bus.stall ? r_addr : w_addr_new;
    assign bus.imem_rden    = !rst && (bus.stall ? r_rden : w_any);
    assign bus.imem_wren    = 1'b0;
    assign bus.imem_data    = '0;

    assign bus.instr_valid  = r_iss.vld && !w_resp_kill;
    assign bus.instr        = bus.imem_q;
    assign bus.instr_pc     = r_iss.pc;
    assign bus.instr_tid    = r_iss.tid;

`ifdef GPC_4T_FETCH_PERF_EN
    logic [NUM_THREADS-1:0][31:0] r_fetch_cnt;
    logic [15:0]                  r_kill_cnt;
    logic [16:0]                  w_kill_sum;

    assign w_kill_sum = {1'b0, r_kill_cnt} + 17'(w_issue_kill) + 17'(w_resp_kill);

    // Saturating counters: fetches consumed by decode, and killed fetches.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_kill_cnt  <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (bus.instr_valid && !bus.stall && r_iss.tid == t_tid'(t) &&
                    r_fetch_cnt[t] != '1)
                    r_fetch_cnt[t] <= r_fetch_cnt[t] + 32'd1;
            end
            r_kill_cnt <= w_kill_sum[16] ? 16'hFFFF : w_kill_sum[15:0];
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_kill_cnt  = r_kill_cnt;
`endif

endmodule

// File: tb/tb_gpc_4t_fetch.sv
// Directed bench for gpc_4t_fetch with a registered instruction memory model.
module tb_gpc_4t_fetch;
    import gpc_4t_fetch_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [31:0] mem [512];

    gpc_4t_fetch_if u_if ();

`ifdef GPC_4T_FETCH_PERF_EN
    logic [NUM_THREADS*32-1:0] perf_fetch_cnt;
    logic [15:0]               perf_kill_cnt;
    gpc_4t_fetch u_dut (.clock(clk), .rst(rst), .bus(u_if),
                        .perf_fetch_cnt(perf_fetch_cnt), .perf_kill_cnt(perf_kill_cnt));
`else
    gpc_4t_fetch u_dut (.clock(clk), .rst(rst), .bus(u_if));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word at byte address a is 0xA000_0000 | (a >> 2).
    always @(posedge clk)
        if (u_if.imem_rden) u_if.imem_q <= mem[u_if.imem_address[10:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check one cycle's outputs, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic e_rden, input logic [31:0] e_addr,
                       input logic e_vld, input logic [31:0] e_pc, input logic [1:0] e_tid);
        #1;
        chk({tag, ".rden"}, 32'(u_if.imem_rden), 32'(e_rden));
        if (e_rden) chk({tag, ".addr"}, u_if.imem_address, e_addr);
        chk({tag, ".vld"}, 32'(u_if.instr_valid), 32'(e_vld));
        if (e_vld) begin
            chk({tag, ".pc"}, u_if.instr_pc, e_pc);
            chk({tag, ".tid"}, 32'(u_if.instr_tid), 32'(e_tid));
            chk({tag, ".instr"}, u_if.instr, 32'hA000_0000 | (e_pc >> 2));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 | 32'(i);
        rst = 1'b1;
        u_if.thread_en  = '0;
        u_if.stall      = 1'b0;
        u_if.jmp_valid  = 1'b0;
        u_if.jmp_tid    = '0;
        u_if.jmp_target = '0;
        #12;
        chk("rst.rden", 32'(u_if.imem_rden), 32'd0);
        chk("rst.addr", u_if.imem_address, 32'h000);
        chk("rst.vld",  32'(u_if.instr_valid), 32'd0);
        chk("rst.pc",   u_if.instr_pc, 32'h0);
        chk("rst.tid",  32'(u_if.instr_tid), 32'd0);
        chk("rst.wren", 32'(u_if.imem_wren), 32'd0);
        chk("rst.data", u_if.imem_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // All threads enabled: 0,1,2,3,0,1...
        u_if.thread_en = 4'b1111;
        cyc("A0", 1, 32'h000, 0, 32'h000, 0);
        cyc("A1", 1, 32'h200, 1, 32'h000, 0);
        cyc("A2", 1, 32'h400, 1, 32'h200, 1);
        cyc("A3", 1, 32'h600, 1, 32'h400, 2);
        cyc("A4", 1, 32'h004, 1, 32'h600, 3);
        cyc("A5", 1, 32'h204, 1, 32'h004, 0);

        // Threads 0 and 2 only.
        u_if.thread_en = 4'b0101;
        cyc("B0", 1, 32'h404, 1, 32'h204, 1);
        cyc("B1", 1, 32'h008, 1, 32'h404, 2);
        cyc("B2", 1, 32'h408, 1, 32'h008, 0);
        cyc("B3", 1, 32'h00C, 1, 32'h408, 2);
        cyc("B4", 1, 32'h40C, 1, 32'h00C, 0);

        // Three-cycle stall: everything frozen, then resume without gaps.
        u_if.stall = 1'b1;
        cyc("S0", 1, 32'h40C, 1, 32'h40C, 2);
        cyc("S1", 1, 32'h40C, 1, 32'h40C, 2);
        cyc("S2", 1, 32'h40C, 1, 32'h40C, 2);
        u_if.stall = 1'b0;
        cyc("R0", 1, 32'h010, 1, 32'h40C, 2);
        cyc("R1", 1, 32'h410, 1, 32'h010, 0);

        // No thread enabled: in-flight fetch completes, then idle.
        u_if.thread_en = 4'b0000;
        cyc("D0", 0, 32'h000, 1, 32'h410, 2);
        cyc("D1", 0, 32'h000, 0, 32'h000, 0);

        u_if.thread_en = 4'b1111;
        cyc("E0", 1, 32'h604, 0, 32'h000, 0);
        cyc("E1", 1, 32'h014, 1, 32'h604, 3);
        cyc("E2", 1, 32'h208, 1, 32'h014, 0);
        // Redirect thread 1 while its fetch of 0x208 is in flight.
        u_if.jmp_valid  = 1'b1;
        u_if.jmp_tid    = 2'd1;
        u_if.jmp_target = 32'h103;
        cyc("E3", 1, 32'h414, 0, 32'h208, 1);
        u_if.jmp_valid  = 1'b0;
        cyc("E4", 1, 32'h608, 1, 32'h414, 2);
        cyc("E5", 1, 32'h018, 1, 32'h608, 3);
        cyc("E6", 1, 32'h100, 1, 32'h018, 0);
        cyc("E7", 1, 32'h418, 1, 32'h100, 1);
        cyc("E8", 1, 32'h60C, 1, 32'h418, 2);
        cyc("E9", 1, 32'h01C, 1, 32'h60C, 3);
        cyc("E10", 1, 32'h104, 1, 32'h01C, 0);
        cyc("E11", 1, 32'h41C, 1, 32'h104, 1);
        // Redirect thread 3 in the cycle it is selected: issue is killed.
        u_if.jmp_valid  = 1'b1;
        u_if.jmp_tid    = 2'd3;
        u_if.jmp_target = 32'h7FD;
        cyc("E12", 1, 32'h610, 1, 32'h41C, 2);
        u_if.jmp_valid  = 1'b0;
        cyc("F0", 1, 32'h020, 0, 32'h000, 0);
        cyc("F1", 1, 32'h108, 1, 32'h020, 0);
        cyc("F2", 1, 32'h420, 1, 32'h108, 1);
        cyc("F3", 1, 32'h7FC, 1, 32'h420, 2);
        cyc("F4", 1, 32'h024, 1, 32'h7FC, 3);
        cyc("F5", 1, 32'h10C, 1, 32'h024, 0);
        cyc("F6", 1, 32'h424, 1, 32'h10C, 1);
        cyc("F7", 1, 32'h000, 1, 32'h424, 2);
        cyc("F8", 1, 32'h028, 1, 32'h000, 3);

        // Asynchronous reset mid-cycle.
        #2;
        rst = 1'b1;
        #1;
        chk("arst.rden", 32'(u_if.imem_rden), 32'd0);
        chk("arst.addr", u_if.imem_address, 32'h000);
        chk("arst.vld",  32'(u_if.instr_valid), 32'd0);
        chk("arst.pc",   u_if.instr_pc, 32'h0);
        chk("arst.tid",  32'(u_if.instr_tid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("G0", 1, 32'h000, 0, 32'h000, 0);
        cyc("G1", 1, 32'h200, 1, 32'h000, 0);
        cyc("G2", 1, 32'h400, 1, 32'h200, 1);
        cyc("G3", 1, 32'h600, 1, 32'h400, 2);
        cyc("G4", 1, 32'h004, 1, 32'h600, 3);

        // Thread 0 alone: 8 fetches, then one killed issue.
        rst = 1'b1;
        u_if.thread_en = 4'b0001;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++)
            cyc($sformatf("P%0d", k), 1, 32'(4 * k), k > 0, 32'(4 * (k - 1)), 0);
        u_if.thread_en = 4'b0000;
        cyc("P8", 0, 32'h000, 1, 32'h01C, 0);
        u_if.thread_en  = 4'b0001;
        u_if.jmp_valid  = 1'b1;
        u_if.jmp_tid    = 2'd0;
        u_if.jmp_target = 32'h040;
        cyc("P9", 1, 32'h020, 0, 32'h000, 0);
        u_if.thread_en  = 4'b0000;
        u_if.jmp_valid  = 1'b0;
        cyc("P10", 0, 32'h000, 0, 32'h000, 0);
`ifdef GPC_4T_FETCH_PERF_EN
        chk("perf.fetch0", perf_fetch_cnt[31:0], 32'd8);
        chk("perf.fetch1", perf_fetch_cnt[63:32], 32'd0);
        chk("perf.kill",   32'(perf_kill_cnt), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
